// File: rtl/irig_b_pkg.sv
// Shared constants, time-of-year record and helpers for the
// IRIG-B encoder and its time-of-year counter.
package irig_b_pkg;

   localparam int CLKS_PER_BIT   = 100;
   localparam int BITS_PER_FRAME = 100;
   localparam int CNT_W          = 7;

   localparam int HI_P    = 80;
   localparam int HI_ONE  = 50;
   localparam int HI_ZERO = 20;

   localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_FRAME - 1);

   localparam int SEC_U  = 1;
   localparam int SEC_T  = 6;
   localparam int MIN_U  = 10;
   localparam int MIN_T  = 15;
   localparam int HOUR_U = 20;
   localparam int HOUR_T = 25;
   localparam int DAY_U  = 30;
   localparam int DAY_T  = 35;
   localparam int DAY_H  = 40;
   localparam int YEAR_U = 50;
   localparam int YEAR_T = 55;

   localparam int SBS_BIT = 80;
   localparam int SBS_W   = 17;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } enc_state_t;

   typedef struct packed {
      logic [7:0] year;
      logic [9:0] day;
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
   } irig_time_t;

   localparam irig_time_t RESET_TIME = '{
      year: 8'h00, day: 10'h001,
      hour: 8'h00, min: 8'h00, sec: 8'h00
   };

   function automatic logic is_marker(
      input logic [CNT_W-1:0] b
   );
      return b inside {
         7'd0,  7'd9,  7'd19, 7'd29, 7'd39, 7'd49,
         7'd59, 7'd69, 7'd79, 7'd89, 7'd99
      };
   endfunction

   function automatic logic [CNT_W-1:0] hi_len(
      input logic marker,
      input logic val
   );
      logic [CNT_W-1:0] len;
      unique case (1'b1)
         marker:         len = CNT_W'(HI_P);
         !marker && val: len = CNT_W'(HI_ONE);
         default:        len = CNT_W'(HI_ZERO);
      endcase
      return len;
   endfunction

   function automatic logic [7:0] bcd_inc8(
      input logic [7:0] v
   );
      if (v[3:0] == 4'h9)
         return {v[7:4] + 4'h1, 4'h0};
      return {v[7:4], v[3:0] + 4'h1};
   endfunction

   function automatic logic [9:0] bcd_inc_day(
      input logic [9:0] v
   );
      if (v[3:0] != 4'h9)
         return {v[9:4], v[3:0] + 4'h1};
      if (v[7:4] != 4'h9)
         return {v[9:8], v[7:4] + 4'h1, 4'h0};
      return {v[9:8] + 2'h1, 8'h00};
   endfunction

   // Year divisible by 4, read straight off the BCD digits.
   function automatic logic is_leap(
      input logic [7:0] y
   );
      if (y[4])
         return y[3:0] inside {4'h2, 4'h6};
      return y[3:0] inside {4'h0, 4'h4, 4'h8};
   endfunction

endpackage

// File: rtl/irig_b_time_counter.sv
// BCD time-of-year register with +1 s carry chain, leap
// handling and a load path that overrides the increment.
module irig_b_time_counter
   import irig_b_pkg::*;
(
   input  logic       clk_10Khz,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       load,
   input  irig_time_t load_val,
   output irig_time_t tod
);

   irig_time_t nxt;
   logic       leap;
   logic       c_min;
   logic       c_hour;
   logic       c_day;
   logic       c_year;

   assign leap = is_leap(tod.year);

   always_comb begin
      c_min  = (tod.sec == 8'h59);
      c_hour = c_min && (tod.min == 8'h59);
      c_day  = c_hour && (tod.hour == 8'h23);
      c_year = c_day &&
               ((tod.day == 10'h366) ||
                (tod.day == 10'h365 && !leap));
      nxt     = tod;
      nxt.sec = c_min ? 8'h00 : bcd_inc8(tod.sec);
      if (c_min)
         nxt.min = c_hour ? 8'h00 : bcd_inc8(tod.min);
      if (c_hour)
         nxt.hour = c_day ? 8'h00 : bcd_inc8(tod.hour);
      if (c_day)
         nxt.day = c_year ? 10'h001 : bcd_inc_day(tod.day);
      if (c_year)
         nxt.year = (tod.year == 8'h99) ? 8'h00
                                        : bcd_inc8(tod.year);
   end

   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n)
         tod <= RESET_TIME;
      else if (load)
         tod <= load_val;
      else if (tick)
         tod <= nxt;
   end

endmodule

// File: rtl/irig_b_encoder.sv
// IRIG-B00x encoder: 100 b/s DC-level time code driven from
// a local BCD time-of-year with strobe-loaded time set.
module irig_b_encoder
   import irig_b_pkg::*;
(
   input  logic       clk_10Khz,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       set_stb,
   input  logic [7:0] set_sec,
   input  logic [7:0] set_min,
   input  logic [7:0] set_hour,
   input  logic [9:0] set_day,
   input  logic [7:0] set_year,
   output logic       set_ack,
   output logic       irig_b,
   output logic       pps,
   output logic       frame_busy
);

   enc_state_t             state_q;
   enc_state_t             state_d;
   logic [CNT_W-1:0]       bit_cnt;
   logic [CNT_W-1:0]       smp_cnt;
   logic                   busy;
   logic                   frame_end;
   logic                   frame_start;
   logic                   boundary;
   logic                   apply;
   logic                   pend_vld;
   irig_time_t             pend;
   irig_time_t             live;
   irig_time_t             shadow;
   logic [SBS_W-1:0]       sbs;
   logic [SBS_W-1:0]       sbs_nxt;
   logic [BITS_PER_FRAME-1:0] frame;
   logic                   bit_val;
   logic [CNT_W-1:0]       len;
   logic                   unused_bits;

   assign busy        = (state_q == S_RUN);
   assign frame_busy  = busy;
   assign frame_end   = busy && bit_cnt == LAST_BIT &&
                        smp_cnt == LAST_SMP;
   assign frame_start = busy && bit_cnt == '0 &&
                        smp_cnt == '0;
   assign boundary    = frame_end || (!busy && enable);
   assign apply       = boundary && pend_vld;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (enable) state_d = S_RUN;
         S_RUN:  if (frame_end && !enable) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n) begin
         smp_cnt <= '0;
         bit_cnt <= '0;
      end else if (busy) begin
         if (smp_cnt == LAST_SMP) begin
            smp_cnt <= '0;
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0
                                             : bit_cnt + 7'd1;
         end else begin
            smp_cnt <= smp_cnt + 7'd1;
         end
      end
   end

   // A strobe on the boundary cycle itself stays pending.
   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= RESET_TIME;
         pend_vld <= 1'b0;
      end else if (set_stb) begin
         pend     <= '{year: set_year, day: set_day,
                       hour: set_hour, min: set_min,
                       sec: set_sec};
         pend_vld <= 1'b1;
      end else if (apply) begin
         pend_vld <= 1'b0;
      end
   end

   irig_b_time_counter u_time (
      .clk_10Khz (clk_10Khz),
      .rst_n     (rst_n),
      .tick      (frame_end),
      .load      (apply),
      .load_val  (pend),
      .tod       (live)
   );

   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n)
         shadow <= RESET_TIME;
      else if (frame_start)
         shadow <= live;
   end

   always_comb begin
      sbs_nxt = SBS_W'(shadow.hour[5:4]) * 17'd36000 +
                SBS_W'(shadow.hour[3:0]) * 17'd3600  +
                SBS_W'(shadow.min[6:4])  * 17'd600   +
                SBS_W'(shadow.min[3:0])  * 17'd60    +
                SBS_W'(shadow.sec[6:4])  * 17'd10    +
                SBS_W'(shadow.sec[3:0]);
   end

   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n)
         sbs <= '0;
      else
         sbs <= sbs_nxt;
   end

   assign unused_bits = ^{shadow.sec[7], shadow.min[7],
                          shadow.hour[7:6]};

   always_comb begin
      frame                     = '0;
      frame[SEC_U  +: 4]        = shadow.sec[3:0];
      frame[SEC_T  +: 3]        = shadow.sec[6:4];
      frame[MIN_U  +: 4]        = shadow.min[3:0];
      frame[MIN_T  +: 3]        = shadow.min[6:4];
      frame[HOUR_U +: 4]        = shadow.hour[3:0];
      frame[HOUR_T +: 2]        = shadow.hour[5:4];
      frame[DAY_U  +: 4]        = shadow.day[3:0];
      frame[DAY_T  +: 4]        = shadow.day[7:4];
      frame[DAY_H  +: 2]        = shadow.day[9:8];
      frame[YEAR_U +: 4]        = shadow.year[3:0];
      frame[YEAR_T +: 4]        = shadow.year[7:4];
      frame[SBS_BIT +: SBS_W]   = sbs;
   end

   assign bit_val = frame[bit_cnt];
   assign len     = hi_len(is_marker(bit_cnt), bit_val);

   always_ff @(posedge clk_10Khz or negedge rst_n) begin
      if (!rst_n) begin
         irig_b  <= 1'b0;
         pps     <= 1'b0;
         set_ack <= 1'b0;
      end else begin
         irig_b  <= busy && (smp_cnt < len);
         pps     <= frame_start;
         set_ack <= apply;
      end
   end

endmodule

// File: tb/tb_irig_b_encoder.sv
// Directed bench for irig_b_encoder: measures high widths per
// bit cell, decodes the frame and checks time/SBS/set/reset.
`timescale 1us/1ns
module tb_irig_b_encoder;

   logic       clk_10Khz = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       set_stb;
   logic [7:0] set_sec;
   logic [7:0] set_min;
   logic [7:0] set_hour;
   logic [9:0] set_day;
   logic [7:0] set_year;
   logic       set_ack;
   logic       irig_b;
   logic       pps;
   logic       frame_busy;

   int   n_chk = 0;
   int   n_fail = 0;
   int   w [100];
   int   pps_extra;
   int   ack_cnt;
   logic irig_q = 1'b0;
   logic ack_q = 1'b0;
   logic last_irig = 1'b0;
   logic last_ack = 1'b0;

   irig_b_encoder dut (
      .clk_10Khz  (clk_10Khz),
      .rst_n      (rst_n),
      .enable     (enable),
      .set_stb    (set_stb),
      .set_sec    (set_sec),
      .set_min    (set_min),
      .set_hour   (set_hour),
      .set_day    (set_day),
      .set_year   (set_year),
      .set_ack    (set_ack),
      .irig_b     (irig_b),
      .pps        (pps),
      .frame_busy (frame_busy)
   );

   always #50 clk_10Khz = ~clk_10Khz;

   task automatic chk(input string tag, input int obs,
                      input int want);
      n_chk++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, want);
      end
   endtask

   task automatic step();
      last_irig = irig_q;
      last_ack  = ack_q;
      @(negedge clk_10Khz);
      irig_q = irig_b;
      ack_q  = set_ack;
      if (set_ack) ack_cnt++;
   endtask

   task automatic wait_pps(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 12000 && !ok; i++) begin
         step();
         if (pps) ok = 1'b1;
      end
      chk({tag, " pps_seen"}, int'(ok), 1);
   endtask

   task automatic capture(input int nb, input int set_bit);
      foreach (w[k]) w[k] = 0;
      pps_extra = 0;
      for (int i = 0; i < nb * 100; i++) begin
         if (i > 0) step();
         set_stb = (i == set_bit * 100);
         w[i / 100] += int'(irig_q);
         if (i > 0 && pps) pps_extra++;
      end
      set_stb = 1'b0;
   endtask

   function automatic int fld(input int lsb, input int n);
      int v;
      v = 0;
      for (int i = 0; i < n; i++)
         if (w[lsb + i] == 50) v |= (1 << i);
      return v;
   endfunction

   function automatic bit tb_marker(input int b);
      return (b == 0) || (b % 10 == 9);
   endfunction

   function automatic bit tb_zero(input int b);
      return b inside {5, 14, 18, 24, 27, 28, 34, [42:48],
                       54, [60:78], 97, 98};
   endfunction

   task automatic check_frame(
      input string tag, input int nb,
      input int e_sec, input int e_min, input int e_hour,
      input int e_day, input int e_year, input int e_sbs
   );
      int bad;
      bad = 0;
      for (int b = 0; b < nb; b++) begin
         if (tb_marker(b)) begin
            if (w[b] != 80) bad++;
         end else if (tb_zero(b)) begin
            if (w[b] != 20) bad++;
         end else if (w[b] != 20 && w[b] != 50) begin
            bad++;
         end
      end
      chk({tag, " cells"}, bad, 0);
      chk({tag, " sec"}, fld(6, 3) * 16 + fld(1, 4), e_sec);
      chk({tag, " min"}, fld(15, 3) * 16 + fld(10, 4), e_min);
      chk({tag, " hour"}, fld(25, 2) * 16 + fld(20, 4), e_hour);
      chk({tag, " day"}, fld(40, 2) * 256 + fld(35, 4) * 16 +
          fld(30, 4), e_day);
      chk({tag, " year"}, fld(55, 4) * 16 + fld(50, 4), e_year);
      if (nb == 100)
         chk({tag, " sbs"}, fld(80, 17), e_sbs);
      chk({tag, " pps_once"}, pps_extra, 0);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic do_set(input logic [7:0] s, input logic [7:0] m,
                         input logic [7:0] h, input logic [9:0] d,
                         input logic [7:0] y);
      set_sec  = s;
      set_min  = m;
      set_hour = h;
      set_day  = d;
      set_year = y;
      set_stb  = 1'b1;
      step();
      set_stb  = 1'b0;
   endtask

   initial begin
      int hi;
      int pc;
      rst_n    = 1'b0;
      enable   = 1'b0;
      set_stb  = 1'b0;
      set_sec  = '0;
      set_min  = '0;
      set_hour = '0;
      set_day  = '0;
      set_year = '0;
      ack_cnt  = 0;
      step();
      step();
      chk("rst irig_b", int'(irig_b), 0);
      chk("rst pps", int'(pps), 0);
      chk("rst set_ack", int'(set_ack), 0);
      chk("rst frame_busy", int'(frame_busy), 0);
      rst_n = 1'b1;

      hi = 0;
      pc = 0;
      for (int i = 0; i < 500; i++) begin
         step();
         hi += int'(irig_q);
         pc += int'(pps);
      end
      chk("idle irig_b_high", hi, 0);
      chk("idle pps", pc, 0);
      chk("idle busy", int'(frame_busy), 0);

      enable = 1'b1;
      wait_pps("A");
      chk("A pps_rise", int'({last_irig, irig_q}), 1);
      chk("A busy", int'(frame_busy), 1);
      chk("A no_ack", ack_cnt, 0);
      capture(100, -1);
      chk("A bit0_width", w[0], 80);
      chk("A bit1_width", w[1], 20);
      chk("A bit9_width", w[9], 80);
      check_frame("A", 100, 'h00, 'h00, 'h00, 'h001, 'h00, 0);
      wait_pps("B");
      capture(2, -1);
      chk("B bit1_width", w[1], 50);

      do_reset();
      do_set(8'h59, 8'h59, 8'h23, 10'h365, 8'h23);
      ack_cnt = 0;
      enable  = 1'b1;
      wait_pps("C");
      chk("C ack_start", int'(last_ack), 1);
      capture(100, -1);
      check_frame("C", 100, 'h59, 'h59, 'h23, 'h365, 'h23, 86399);
      wait_pps("D");
      capture(60, -1);
      check_frame("D", 60, 'h00, 'h00, 'h00, 'h001, 'h24, 0);

      do_reset();
      do_set(8'h59, 8'h59, 8'h23, 10'h365, 8'h24);
      enable = 1'b1;
      wait_pps("E");
      capture(100, -1);
      check_frame("E", 100, 'h59, 'h59, 'h23, 'h365, 'h24, 86399);
      wait_pps("F");
      capture(60, -1);
      check_frame("F", 60, 'h00, 'h00, 'h00, 'h366, 'h24, 0);

      do_reset();
      do_set(8'h59, 8'h59, 8'h23, 10'h366, 8'h24);
      enable = 1'b1;
      wait_pps("G");
      capture(100, -1);
      check_frame("G", 100, 'h59, 'h59, 'h23, 'h366, 'h24, 86399);
      wait_pps("H");
      capture(60, -1);
      check_frame("H", 60, 'h00, 'h00, 'h00, 'h001, 'h25, 0);

      do_reset();
      do_set(8'h56, 8'h34, 8'h12, 10'h001, 8'h00);
      ack_cnt = 0;
      enable  = 1'b1;
      wait_pps("I");
      chk("I ack_start", int'(last_ack), 1);
      chk("I ack_cnt", ack_cnt, 1);
      set_sec  = 8'h42;
      set_min  = 8'h15;
      set_hour = 8'h08;
      set_day  = 10'h123;
      set_year = 8'h21;
      ack_cnt  = 0;
      capture(100, 50);
      check_frame("I", 100, 'h56, 'h34, 'h12, 'h001, 'h00, 45296);
      wait_pps("J");
      chk("J ack_boundary", int'(last_ack), 1);
      chk("J ack_cnt", ack_cnt, 1);
      capture(60, -1);
      check_frame("J", 60, 'h42, 'h15, 'h08, 'h123, 'h21, 0);

      for (int i = 0; i < 5; i++) step();
      chk("pre_rst irig_b", int'(irig_q), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst irig_b", int'(irig_b), 0);
      chk("mid_rst busy", int'(frame_busy), 0);
      chk("mid_rst pps", int'(pps), 0);
      step();
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
